mtm_alu_deserializer: RTL and testbench
=======================================

Name: mtm_alu_deserializer

Overview:
- Serial input stage of the mtm_Alu datapath. Sits between the `sin` pin and the ALU core.
- Decodes the one-bit-per-clock framed byte stream and assembles 8 data bytes (B then A) plus one CMD byte.
- Checks the CMD byte's CRC4 and opcode.
- Hands the core either a validated operand/op set or a one-hot error code, as single-cycle pulses.

Parameters:
- DATA_BYTES, 8, data bytes expected before the CMD byte (B: 4, A: 4).
- CRC_INIT, 4'b0000, CRC4 LFSR seed.

Ports:
- clk  in  1  posedge clock; one serial bit per cycle.
- rst  in  1  synchronous reset, active-high.
- sin  in  1  serial input; idle level 1.
- out_valid  out  1  one-cycle pulse: A, B, op valid.
- out_a  out  32  operand A.
- out_b  out  32  operand B.
- out_op  out  3  opcode.
- err_valid  out  1  one-cycle pulse: err_flags valid.
- err_flags  out  3  one-hot: [2]=ERR_DATA, [1]=ERR_CRC, [0]=ERR_OP.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high, named clk / rst.
  - On rst: state=IDLE; byte_cnt=0; shift register=0; all outputs 0.
  - Reset mid-packet discards all partial data. No output is pulsed for the discarded packet.
- Frame format (11 cycles): start 0, type bit (0=DATA, 1=CMD), 8 payload bits MSB first, stop 1.
- States:
  - IDLE: sin==0 -> TYPE; else stay.
  - TYPE: latch type bit -> BITS; bit_cnt=0.
  - BITS: shift sin in, bit_cnt++; after 8th bit -> STOP.
  - STOP: sin==1 -> commit byte, then IDLE. sin==0 -> frame_err pulse, drop packet (byte_cnt=0), then WAIT_IDLE.
  - WAIT_IDLE: stay until sin==1, then IDLE.
- Data commit:
  - DATA byte shifts into the 64-bit {B,A} register; byte_cnt increments.
  - byte_cnt saturates at 9. A 9th data byte marks overflow.
- CMD commit:
  - CMD byte = {0, op[2:0], crc4}.
  - Error priority: data > crc > op. Only one err bit is ever set.
  - byte_cnt != 8 -> ERR_DATA.
  - Else CRC4({B,A,1'b1,op}) != crc4 -> ERR_CRC.
  - Else op not in {000 AND, 001 OR, 100 ADD, 101 SUB} -> ERR_OP.
  - Else out_valid.
  - byte_cnt returns to 0 after any CMD.
- CRC4:
  - Polynomial x^4+x+1, seed CRC_INIT.
  - 68 bits fed MSB first: B[31] first, op[0] last.
  - Must match nextCRC4_D68(data, 4'b0000).
- Latency:
  - out_valid / err_valid / frame_err assert in the cycle after the CMD stop bit is sampled.
  - Pulses are exactly 1 cycle.
  - out_a/out_b/out_op hold their value until the next out_valid.
  - err_flags holds until the next err_valid.
- No backpressure: the core must accept every pulse.
- A new start bit may be sampled in the cycle after STOP. Back-to-back frames with no idle gap are legal.
- Bytes are B[31:24], B[23:16], B[15:8], B[7:0], then A in the same order.

Test Plan:
- Valid ADD: B=32'h00000002, A=32'h00000001, op=100, correct CRC -> one out_valid, 1 cycle after CMD stop; out_b=2, out_a=1, out_op=100; err_valid stays 0.
- CRC error: A=32'hFFFFFFFF, B=0, op=000, crc4 with bit0 flipped -> err_valid with err_flags=3'b010; no out_valid.
- Short packet: 2 data bytes then CMD with correct CRC -> err_flags=3'b100. Then a full valid packet -> out_valid (byte_cnt was cleared).
- Bad op: op=011 with CRC recomputed over op=011 -> err_flags=3'b001. Same packet also sent with 3 data bytes -> err_flags=3'b100 (priority check).
- Framing: stop bit forced 0 on the 5th byte -> frame_err pulse, no err/out pulse. Hold sin=0 for 5 cycles, then 1 -> next valid packet decodes correctly.
- Reset mid-packet: assert rst for 1 cycle after 6 data bytes -> all outputs 0, then a fresh valid SUB packet (B=5, A=7) -> out_valid with out_op=101.
- Back-to-back: two valid packets with zero idle gap -> two out_valid pulses exactly 99 cycles apart.

Source files
------------

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: frames the serial sin stream into {B,A} and CMD bytes and emits checked operand or error pulses
// Ports:
//   clk, rst         clock (one serial bit per cycle), synchronous active-high reset
//   sin              serial input, idles high
//   out_valid        one-cycle pulse, out_a/out_b/out_op valid (held until next pulse)
//   out_a, out_b     32-bit operands
//   out_op           3-bit opcode
//   err_valid        one-cycle pulse, err_flags valid (held until next pulse)
//   err_flags        one-hot {ERR_DATA, ERR_CRC, ERR_OP}
//   frame_err        one-cycle pulse when a stop bit is sampled low
module mtm_alu_deserializer #(
    parameter int DATA_BYTES = 8,
    parameter logic [3:0] CRC_INIT = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op,
    output logic        err_valid,
    output logic [2:0]  err_flags,
    output logic        frame_err
);
    typedef enum logic [2:0] {IDLE, TYPE, BITS, STOP, WAIT_IDLE} state_t;
    localparam logic [3:0] FULL = 4'(DATA_BYTES);
    localparam logic [3:0] SAT  = 4'(DATA_BYTES + 1);
    state_t      state, state_nxt;
    logic        is_cmd;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic [63:0] data;
    logic [3:0]  byte_cnt;
    logic [2:0]  op;
    logic        op_ok;
    logic [2:0]  err_code;
    // Serial Galois LFSR for x^4+x+1, message fed MSB first.
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = CRC_INIT;
        for (int i = 67; i >= 0; i--) begin
            fb = d[i] ^ c[3];
            c  = {c[2:1], c[0] ^ fb, fb};
        end
        return c;
    endfunction
    assign op    = shift[6:4];
    assign op_ok = op inside {3'b000, 3'b001, 3'b100, 3'b101};
    // Priority data > crc > op keeps the flag one-hot.
    assign err_code = (byte_cnt != FULL)                       ? 3'b100 :
                      (crc4({data, 1'b1, op}) != shift[3:0])   ? 3'b010 :
                      !op_ok                                   ? 3'b001 : 3'b000;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = sin ? IDLE : TYPE;
            TYPE:      state_nxt = BITS;
            BITS:      state_nxt = (bit_cnt == 3'd7) ? STOP : BITS;
            STOP:      state_nxt = sin ? IDLE : WAIT_IDLE;
            WAIT_IDLE: state_nxt = sin ? IDLE : WAIT_IDLE;
            default:   state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            is_cmd    <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            data      <= '0;
            byte_cnt  <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_op    <= '0;
            err_valid <= 1'b0;
            err_flags <= '0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                TYPE: begin
                    is_cmd  <= sin;
                    bit_cnt <= '0;
                end
                BITS: begin
                    shift   <= {shift[6:0], sin};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                STOP: begin
                    if (!sin) begin
                        frame_err <= 1'b1;
                        byte_cnt  <= '0;
                    end else if (!is_cmd) begin
                        data     <= {data[55:0], shift};
                        byte_cnt <= (byte_cnt == SAT) ? SAT : byte_cnt + 4'd1;
                    end else begin
                        byte_cnt <= '0;
                        if (err_code != 3'b000) begin
                            err_valid <= 1'b1;
                            err_flags <= err_code;
                        end else begin
                            out_valid <= 1'b1;
                            out_b     <= data[63:32];
                            out_a     <= data[31:0];
                            out_op    <= op;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer: randomized and directed checks of the deserializer against a packet-level model
module tb_mtm_alu_deserializer;
    logic        clk = 0, rst = 1, sin = 1;
    logic        out_valid, err_valid, frame_err;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_op, err_flags;
    int errors = 0, checks = 0;
    int cyc = 0, n_ov = 0, n_ev = 0, n_fe = 0, prev_ov_cyc = 0, last_ov_cyc = 0;
    logic [7:0]  pb[16];
    int          pn;
    logic [7:0]  pcmd;
    logic        cap_ov, cap_ev, cap_fe, cap_next;
    logic [31:0] cap_a, cap_b;
    logic [2:0]  cap_op, cap_flags;

    mtm_alu_deserializer dut (
        .clk(clk), .rst(rst), .sin(sin), .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
        .out_op(out_op), .err_valid(err_valid), .err_flags(err_flags), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (out_valid) begin
            n_ov++;
            prev_ov_cyc = last_ov_cyc;
            last_ov_cyc = cyc;
        end
        if (err_valid) n_ev++;
        if (frame_err) n_fe++;
    end

    // CRC as remainder of M(x)*x^4 divided by x^4+x+1 (zero seed).
    function automatic logic [3:0] ref_crc(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
        logic [71:0] m;
        m = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
        return m[3:0];
    endfunction

    function automatic logic [2:0] ref_err(input int n, input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op, input logic [3:0] crc);
        if (n != 8) return 3'b100;
        if (crc != ref_crc(b, a, op)) return 3'b010;
        if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) return 3'b001;
        return 3'b000;
    endfunction

    task automatic send_bit(input logic v);
        @(negedge clk);
        sin = v;
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic build(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op,
                         input logic [3:0] crc, input int n);
        logic [63:0] ba;
        ba = {b, a};
        pn = n;
        for (int i = 0; i < n; i++) pb[i] = (i < 8) ? ba[63 - 8*i -: 8] : 8'($urandom);
        pcmd = {1'b0, op, crc};
    endtask

    task automatic capture();
        cap_ov = out_valid; cap_ev = err_valid; cap_fe = frame_err;
        cap_a = out_a; cap_b = out_b; cap_op = out_op; cap_flags = err_flags;
    endtask

    // bad >= 0 forces the stop bit of that data frame low and ends the packet there.
    task automatic run_pkt(input int bad);
        for (int i = 0; i < pn; i++) begin
            send_frame(1'b0, pb[i], i != bad);
            if (i == bad) begin
                @(negedge clk);
                sin = 0;
                capture();
                return;
            end
        end
        send_frame(1'b1, pcmd, 1'b1);
        @(negedge clk);
        sin = 1;
        capture();
        @(negedge clk);
        cap_next = out_valid | err_valid | frame_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst = 0;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid: got %b expected 0", err_valid); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++;
        if ({out_a, out_b, out_op, err_flags} !== 70'd0) begin
            errors++; $display("FAIL reset_data: got a=%h b=%h op=%b flags=%b expected all 0", out_a, out_b, out_op, err_flags);
        end
        checks++;
    endtask

    task automatic test_valid_add();
        build(32'h2, 32'h1, 3'b100, ref_crc(32'h2, 32'h1, 3'b100), 8);
        run_pkt(-1);
        if (cap_ov !== 1'b1 || cap_ev !== 1'b0) begin errors++; $display("FAIL add_pulse: got ov=%b ev=%b expected ov=1 ev=0", cap_ov, cap_ev); end
        checks++;
        if (cap_a !== 32'h1 || cap_b !== 32'h2 || cap_op !== 3'b100) begin
            errors++; $display("FAIL add_data: got a=%h b=%h op=%b expected a=1 b=2 op=100", cap_a, cap_b, cap_op);
        end
        checks++;
        if (cap_next !== 1'b0) begin errors++; $display("FAIL add_pulse_width: got %b expected 0 on second cycle", cap_next); end
        checks++;
    endtask

    task automatic test_crc_err();
        build(32'h0, 32'hFFFF_FFFF, 3'b000, ref_crc(32'h0, 32'hFFFF_FFFF, 3'b000) ^ 4'b0001, 8);
        run_pkt(-1);
        if (cap_ev !== 1'b1 || cap_ov !== 1'b0 || cap_flags !== 3'b010) begin
            errors++; $display("FAIL crc_err: got ev=%b ov=%b flags=%b expected ev=1 ov=0 flags=010", cap_ev, cap_ov, cap_flags);
        end
        checks++;
    endtask

    task automatic test_short();
        build(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, ref_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b001), 2);
        run_pkt(-1);
        if (cap_ev !== 1'b1 || cap_flags !== 3'b100) begin errors++; $display("FAIL short_pkt: got ev=%b flags=%b expected ev=1 flags=100", cap_ev, cap_flags); end
        checks++;
        build(32'h1234_5678, 32'h9ABC_DEF0, 3'b001, ref_crc(32'h1234_5678, 32'h9ABC_DEF0, 3'b001), 8);
        run_pkt(-1);
        if (cap_ov !== 1'b1 || cap_a !== 32'h9ABC_DEF0 || cap_b !== 32'h1234_5678) begin
            errors++; $display("FAIL after_short: got ov=%b a=%h b=%h expected ov=1 a=9abcdef0 b=12345678", cap_ov, cap_a, cap_b);
        end
        checks++;
    endtask

    task automatic test_bad_op();
        build(32'hA5, 32'h5A, 3'b011, ref_crc(32'hA5, 32'h5A, 3'b011), 8);
        run_pkt(-1);
        if (cap_ev !== 1'b1 || cap_flags !== 3'b001 || cap_ov !== 1'b0) begin
            errors++; $display("FAIL bad_op: got ev=%b ov=%b flags=%b expected ev=1 ov=0 flags=001", cap_ev, cap_ov, cap_flags);
        end
        checks++;
        build(32'hA5, 32'h5A, 3'b011, ref_crc(32'hA5, 32'h5A, 3'b011), 3);
        run_pkt(-1);
        if (cap_flags !== 3'b100) begin errors++; $display("FAIL err_priority: got flags=%b expected 100", cap_flags); end
        checks++;
    endtask

    task automatic test_framing();
        int ov0, ev0;
        ov0 = n_ov; ev0 = n_ev;
        build(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b101, ref_crc(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b101), 8);
        run_pkt(4);
        if (cap_fe !== 1'b1 || cap_ov !== 1'b0 || cap_ev !== 1'b0) begin
            errors++; $display("FAIL frame_err: got fe=%b ov=%b ev=%b expected fe=1 ov=0 ev=0", cap_fe, cap_ov, cap_ev);
        end
        checks++;
        repeat (5) send_bit(1'b0);
        repeat (2) send_bit(1'b1);
        if (n_ov !== ov0 || n_ev !== ev0) begin errors++; $display("FAIL frame_no_pulse: got ov=%0d ev=%0d pulses expected 0", n_ov - ov0, n_ev - ev0); end
        checks++;
        build(32'h11, 32'h22, 3'b000, ref_crc(32'h11, 32'h22, 3'b000), 8);
        run_pkt(-1);
        if (cap_ov !== 1'b1 || cap_a !== 32'h22 || cap_b !== 32'h11 || cap_op !== 3'b000) begin
            errors++; $display("FAIL after_frame_err: got ov=%b a=%h b=%h op=%b expected ov=1 a=22 b=11 op=000", cap_ov, cap_a, cap_b, cap_op);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int ov0, ev0;
        build(32'hCAFE_0001, 32'h7777_8888, 3'b100, ref_crc(32'hCAFE_0001, 32'h7777_8888, 3'b100), 8);
        for (int i = 0; i < 6; i++) send_frame(1'b0, pb[i], 1'b1);
        @(negedge clk);
        sin = 1; rst = 1;
        @(negedge clk);
        rst = 0;
        if ({out_valid, err_valid, frame_err, out_a, out_b, out_op, err_flags} !== 73'd0) begin
            errors++; $display("FAIL reset_mid: got a=%h b=%h op=%b flags=%b expected all 0", out_a, out_b, out_op, err_flags);
        end
        checks++;
        ov0 = n_ov; ev0 = n_ev;
        build(32'h5, 32'h7, 3'b101, ref_crc(32'h5, 32'h7, 3'b101), 8);
        run_pkt(-1);
        if (cap_ov !== 1'b1 || cap_op !== 3'b101 || cap_a !== 32'h7 || cap_b !== 32'h5) begin
            errors++; $display("FAIL sub_after_reset: got ov=%b op=%b a=%h b=%h expected ov=1 op=101 a=7 b=5", cap_ov, cap_op, cap_a, cap_b);
        end
        checks++;
        if (n_ov - ov0 !== 1 || n_ev !== ev0) begin errors++; $display("FAIL reset_pulses: got ov=%0d ev=%0d expected ov=1 ev=0", n_ov - ov0, n_ev - ev0); end
        checks++;
    endtask

    task automatic test_back_to_back();
        int ov0;
        ov0 = n_ov;
        for (int p = 0; p < 2; p++) begin
            logic [31:0] b, a;
            b = $urandom; a = $urandom;
            build(b, a, 3'b001, ref_crc(b, a, 3'b001), 8);
            for (int i = 0; i < 8; i++) send_frame(1'b0, pb[i], 1'b1);
            send_frame(1'b1, pcmd, 1'b1);
        end
        repeat (4) send_bit(1'b1);
        if (n_ov - ov0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d pulses expected 2", n_ov - ov0); end
        checks++;
        if (last_ov_cyc - prev_ov_cyc !== 99) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 99", last_ov_cyc - prev_ov_cyc); end
        checks++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            logic [31:0] b, a;
            logic [2:0]  op, exp;
            logic [3:0]  crc;
            int          n;
            b = $urandom; a = $urandom; op = 3'($urandom);
            crc = ref_crc(b, a, op);
            if ($urandom_range(0, 3) == 0) crc = crc ^ 4'($urandom_range(1, 15));
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 10) : 8;
            exp = ref_err(n, b, a, op, crc);
            build(b, a, op, crc, n);
            run_pkt(-1);
            if (exp == 3'b000) begin
                if (cap_ov !== 1'b1 || cap_ev !== 1'b0 || cap_a !== a || cap_b !== b || cap_op !== op) begin
                    errors++; $display("FAIL rand_valid[%0d]: got ov=%b ev=%b a=%h b=%h op=%b expected ov=1 ev=0 a=%h b=%h op=%b",
                                       t, cap_ov, cap_ev, cap_a, cap_b, cap_op, a, b, op);
                end
            end else begin
                if (cap_ev !== 1'b1 || cap_ov !== 1'b0 || cap_flags !== exp) begin
                    errors++; $display("FAIL rand_err[%0d]: got ev=%b ov=%b flags=%b expected ev=1 ov=0 flags=%b",
                                       t, cap_ev, cap_ov, cap_flags, exp);
                end
            end
            checks++;
            if (cap_next !== 1'b0) begin errors++; $display("FAIL rand_width[%0d]: got %b expected 0", t, cap_next); end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_valid_add();
        test_crc_err();
        test_short();
        test_bad_op();
        test_framing();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
